// File: rtl/spic_arbiter.sv
// Round-robin arbiter that feeds instructions from NREQ requesters into a
// pipelined SPI master (one staged + one in-flight slot) and routes results back.

package spic_pkg;
  parameter int INSTR_SIZE   = 32;
  parameter int DWIDTH       = 8;
  parameter int S_ADDR_WIDTH = 8;
endpackage

module spic_arbiter
  import spic_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*INSTR_SIZE-1:0] req_instr,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DWIDTH-1:0]          rsp_data,
  output logic                       rsp_write,
  input  logic [1:0]                 cfg_in,
  input  logic                       driver_read,
  input  logic [DWIDTH-1:0]          spi_slv_read_data,
  output logic                       master_en,
  output logic [INSTR_SIZE-1:0]      driver_data,
  output logic [1:0]                 driver_cfg,
  output logic                       timeout_err
);

  localparam int PW   = $clog2(NREQ);
  localparam int WW   = $clog2(TIMEOUT + 1);
  localparam int WBIT = INSTR_SIZE - S_ADDR_WIDTH - 2;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic                    master_en_q, master_en_d;
  logic [INSTR_SIZE-1:0]   drv_data_q, drv_data_d;
  logic [1:0]              drv_cfg_q, drv_cfg_d;
  logic                    stg_vld_q, stg_vld_d;
  logic [PW-1:0]           stg_own_q, stg_own_d;
  logic                    inf_vld_q, inf_vld_d;
  logic [PW-1:0]           inf_own_q, inf_own_d;
  logic                    inf_wr_q, inf_wr_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [WW-1:0]           wd_q, wd_d;
  logic                    err_q, err_d;

  logic                    accept, close, grant_ok, gnt_any;
  logic [PW-1:0]           gnt_idx, idx;

  // Handshake: req_ready[i] is a one-hot grant; requester i's instruction is
  // consumed at the rising edge where req_valid[i] && req_ready[i]. The SPI
  // master consumes driver_data at every edge where driver_read && master_en.
  assign accept   = driver_read && (state_q == RUN);
  assign close    = accept && !stg_vld_q;
  assign grant_ok = !close && ((state_q == IDLE) || !stg_vld_q || accept);

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (!grant_ok) gnt_any = 1'b0;
  end

  assign req_ready = (gnt_any && rst_n) ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d     = state_q;
    drv_data_d  = drv_data_q;
    drv_cfg_d   = drv_cfg_q;
    stg_vld_d   = stg_vld_q;
    stg_own_d   = stg_own_q;
    inf_vld_d   = inf_vld_q;
    inf_own_d   = inf_own_q;
    inf_wr_d    = inf_wr_q;
    ptr_d       = ptr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_write_d = rsp_write_q;

    if (accept && inf_vld_q) begin
      rsp_valid_d = NREQ'(1) << inf_own_q;
      rsp_write_d = inf_wr_q;
      rsp_data_d  = inf_wr_q ? '0 : spi_slv_read_data;
    end

    if (accept) begin
      if (stg_vld_q) begin
        inf_vld_d = 1'b1;
        inf_own_d = stg_own_q;
        inf_wr_d  = drv_data_q[WBIT];
        stg_vld_d = 1'b0;
      end else begin
        inf_vld_d = 1'b0;
        state_d   = IDLE;
      end
    end

    if (gnt_any) begin
      stg_vld_d  = 1'b1;
      stg_own_d  = gnt_idx;
      drv_data_d = req_instr[int'(gnt_idx)*INSTR_SIZE +: INSTR_SIZE];
      ptr_d      = gnt_idx;
      if (state_q == IDLE) begin
        state_d   = RUN;
        drv_cfg_d = cfg_in;
      end
    end

    master_en_d = (state_d == RUN);

    // Watchdog saturates at TIMEOUT; the error flag is sticky until reset.
    if ((state_q == RUN) && !accept)
      wd_d = (wd_q == WW'(TIMEOUT)) ? wd_q : wd_q + 1'b1;
    else
      wd_d = '0;
    err_d = err_q || (wd_d == WW'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      master_en_q <= 1'b0;
      drv_data_q  <= '0;
      drv_cfg_q   <= 2'b00;
      stg_vld_q   <= 1'b0;
      stg_own_q   <= '0;
      inf_vld_q   <= 1'b0;
      inf_own_q   <= '0;
      inf_wr_q    <= 1'b0;
      ptr_q       <= PW'(NREQ - 1);
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_write_q <= 1'b0;
      wd_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      master_en_q <= master_en_d;
      drv_data_q  <= drv_data_d;
      drv_cfg_q   <= drv_cfg_d;
      stg_vld_q   <= stg_vld_d;
      stg_own_q   <= stg_own_d;
      inf_vld_q   <= inf_vld_d;
      inf_own_q   <= inf_own_d;
      inf_wr_q    <= inf_wr_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_write_q <= rsp_write_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
    end
  end

  assign master_en   = master_en_q;
  assign driver_data = drv_data_q;
  assign driver_cfg  = drv_cfg_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_write   = rsp_write_q;
  assign timeout_err = err_q;

endmodule

// File: doc/spic_arbiter.md
SPIC_ARBITER -- requirements
Module: spic_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of instruction requesters (2..8).
REQ-002 Parameter: TIMEOUT, 1024, max RUN cycles without an accepted driver_read before error.
REQ-003 Widths INSTR_SIZE, DWIDTH, S_ADDR_WIDTH SHALL come from spic_pkg.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NREQ  requester i has an instruction pending.
REQ-007 req_instr  in  NREQ*INSTR_SIZE  packed instructions, slice i for requester i.
REQ-008 req_ready  out  NREQ  one-hot grant; requester i's instruction is taken at this edge.
REQ-009 rsp_valid  out  NREQ  one-hot, one-cycle completion pulse to owning requester.
REQ-010 rsp_data  out  DWIDTH  read data for the completing instruction (0 for writes).
REQ-011 rsp_write  out  1  completing instruction was a write.
REQ-012 cfg_in  in  2  SPI mode configuration.
REQ-013 driver_read  in  1  SPI master accepts driver_data and returns prior result this edge.
REQ-014 spi_slv_read_data  in  DWIDTH  read data of the in-flight instruction, valid with driver_read.
REQ-015 master_en  out  1  registered SPI master enable.
REQ-016 driver_data  out  INSTR_SIZE  registered staged instruction.
REQ-017 driver_cfg  out  2  registered SPI configuration.
REQ-018 timeout_err  out  1  sticky watchdog flag.

Function
REQ-019 Two states: IDLE (master_en=0), RUN (master_en=1); master_en SHALL be the registered state decode.
REQ-020 Two slots: staged (valid, owner, instruction on driver_data) and in-flight (valid, owner, is_write).
REQ-021 is_write SHALL be instruction bit INSTR_SIZE-S_ADDR_WIDTH-2 (LSB of T_TYPE).
REQ-022 Accept event: driver_read=1 while master_en=1; driver_read SHALL be ignored when master_en=0.
REQ-023 On accept with in-flight valid: rsp_valid[in-flight owner] pulses next cycle; rsp_data = registered spi_slv_read_data for reads, 0 for writes; rsp_write = is_write.
REQ-024 On accept with staged valid: staged moves to in-flight (owner, is_write); staged valid clears unless refilled the same edge.
REQ-025 On accept with staged empty (close handshake): in-flight retires per REQ-023, state -> IDLE, no grant issued that cycle.
REQ-026 Grant allowed when state=IDLE, or state=RUN and (staged empty or being moved by accept), excluding close cycles.
REQ-027 Grant SHALL be round-robin: search starts one above the last granted index, wraps at NREQ-1 -> 0; pointer updates only on grant.
REQ-028 req_ready is combinational from req_valid, pointer and grant-allowed; at most one bit high; the chosen instruction loads into driver_data at that edge.
REQ-029 Grant in IDLE: state -> RUN same edge; driver_cfg <= cfg_in at that edge; driver_cfg SHALL NOT change while RUN.
REQ-030 After a close, master_en SHALL stay low at least one full cycle before re-entering RUN.
REQ-031 Any requester with req_valid held SHALL be granted within NREQ grants.
REQ-032 Watchdog counter counts RUN cycles since last accept, clears on accept or IDLE; reaching TIMEOUT sets timeout_err; counter saturates; no other effect.
REQ-033 rsp_valid never for a requester without a prior grant; responses SHALL return in grant order.

Reset
REQ-034 rst_n=0 SHALL immediately force: state IDLE, master_en=0, driver_data=0, driver_cfg=2'b00, both slots invalid, pointer to NREQ-1 (first search from 0), rsp_valid=0, rsp_data=0, rsp_write=0, watchdog=0, timeout_err=0.
REQ-035 Reset mid-operation SHALL discard staged and in-flight instructions with no rsp_valid pulse; req_ready=0 while rst_n=0.

Verification
REQ-036 Single read, req 0, instr with T_TYPE LSB=0; driver_read pulses twice, spi_slv_read_data=8'hA5 on second -> req_ready[0] one cycle, master_en rises, rsp_valid[0] with rsp_data=A5, rsp_write=0, then master_en low.
REQ-037 All four requesters held valid after reset, 8 accepts -> grant order 0,1,2,3,0,1,2,3; rsp_valid order identical.
REQ-038 Write from req 2 followed by read from req 1 back-to-back -> rsp_valid[2] rsp_write=1 rsp_data=0, then rsp_valid[1] with read data; driver_data changes only on accepts.
REQ-039 Close then new request same cycle -> no grant on close edge, master_en low exactly one cycle, then RUN with new instruction.
REQ-040 RUN with driver_read held 0, TIMEOUT=16 -> timeout_err set after 16 cycles, stays set after later accepts until reset.
REQ-041 rst_n low with both slots valid -> master_en=0 asynchronously, no rsp_valid, post-reset first grant to lowest valid index.
